// File: rtl/note_maze_pkg.sv
// Shared types and note decode for the note-driven maze game controller.
package note_maze_pkg;

  typedef enum logic [1:0] {LEFT = 2'd0, RIGHT = 2'd1, UP = 2'd2, DOWN = 2'd3} dir_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    FETCH = 3'd2,
    CHECK = 3'd3,
    WON   = 3'd4
  } state_t;

  typedef struct packed {
    logic vld;
    dir_t dir;
  } cmd_t;

  localparam logic [11:0] NOTE_C  = 12'h800;
  localparam logic [11:0] NOTE_CS = 12'h400;
  localparam logic [11:0] NOTE_D  = 12'h200;
  localparam logic [11:0] NOTE_DS = 12'h100;
  localparam logic [11:0] NOTE_E  = 12'h080;
  localparam logic [11:0] NOTE_F  = 12'h040;
  localparam logic [11:0] NOTE_FS = 12'h020;
  localparam logic [11:0] NOTE_G  = 12'h010;
  localparam logic [11:0] NOTE_GS = 12'h008;
  localparam logic [11:0] NOTE_A  = 12'h004;
  localparam logic [11:0] NOTE_AS = 12'h002;
  localparam logic [11:0] NOTE_B  = 12'h001;

  // Exact one-hot match only; zero and multi-hot notes yield vld = 0.
  function automatic cmd_t note_to_dir(input logic [11:0] note);
    cmd_t c;
    c.vld = 1'b1;
    c.dir = LEFT;
    if (note == NOTE_C)      c.dir = LEFT;
    else if (note == NOTE_D) c.dir = RIGHT;
    else if (note == NOTE_E) c.dir = UP;
    else if (note == NOTE_F) c.dir = DOWN;
    else                     c.vld = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO of move directions; pointers carry an extra wrap bit.
module dir_fifo
  import note_maze_pkg::*;
#(
  parameter int unsigned depth = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  dir_t din,
  output logic full,
  output logic empty,
  output dir_t dout
);

  localparam int unsigned AW = $clog2(depth);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_ptr, rd_ptr;
  dir_t        mem [depth];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/note_move_sequencer.sv
// Turns note events into queued moves and executes one wall-checked move per step.
module note_move_sequencer
  import note_maze_pkg::*;
#(
  parameter int unsigned maze_w     = 32,
  parameter int unsigned maze_h     = 18,
  parameter int unsigned start_x    = 1,
  parameter int unsigned start_y    = 1,
  parameter int unsigned goal_x     = 31,
  parameter int unsigned goal_y     = 15,
  parameter int unsigned fifo_depth = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] note,
  input  logic        note_vld,
  input  logic        step,
  output logic        wall_rd,
  output logic [4:0]  wall_x,
  output logic [4:0]  wall_y,
  input  logic        wall_bit,
  output logic [4:0]  player_x,
  output logic [4:0]  player_y,
  output logic [2:0]  state,
  output logic [15:0] moves,
  output logic        won,
  output logic        bump,
  output logic        drop
);

  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] START_X = CW'(start_x);
  localparam logic [CW-1:0] START_Y = CW'(start_y);
  localparam logic [CW-1:0] GOAL_X  = CW'(goal_x);
  localparam logic [CW-1:0] GOAL_Y  = CW'(goal_y);
  localparam logic [CW:0]   LIM_X   = (CW + 1)'(maze_w);
  localparam logic [CW:0]   LIM_Y   = (CW + 1)'(maze_h);

  state_t        state_q, state_nx;
  logic [CW-1:0] px_nx, py_nx, wx_nx, wy_nx;
  logic [15:0]   moves_nx;
  logic          bump_nx, drop_nx;
  cmd_t          cmd;
  logic          push_req, push, pop, flush, restart, in_range;
  logic          full, empty;
  dir_t          head;
  logic [CW:0]   tx, ty;

  dir_fifo #(.depth(fifo_depth)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (cmd.dir),
    .full  (full),
    .empty (empty),
    .dout  (head)
  );

  // Command intake: a full queue only accepts when the head leaves this cycle.
  always_comb begin
    cmd      = note_to_dir(note);
    push_req = note_vld && cmd.vld && (state_q inside {IDLE, RUN, FETCH, CHECK});
    pop      = (state_q == RUN) && step && !empty;
    push     = push_req && (!full || pop);
    drop_nx  = push_req && full && !pop;
    restart  = note_vld && (note == NOTE_A) && (state_q == WON);
  end

  // Target cell in one extra bit so underflow at 0 and overflow at 31 fall out of range.
  always_comb begin
    tx = {1'b0, player_x};
    ty = {1'b0, player_y};
    case (head)
      LEFT:    tx = tx - 6'd1;
      RIGHT:   tx = tx + 6'd1;
      UP:      ty = ty - 6'd1;
      default: ty = ty + 6'd1;
    endcase
    in_range = (tx < LIM_X) && (ty < LIM_Y);
  end

  always_comb begin
    state_nx = state_q;
    px_nx    = player_x;
    py_nx    = player_y;
    wx_nx    = wall_x;
    wy_nx    = wall_y;
    moves_nx = moves;
    bump_nx  = 1'b0;
    flush    = 1'b0;
    case (state_q)
      IDLE: if (push) state_nx = RUN;
      RUN: begin
        if (pop) begin
          if (in_range) begin
            wx_nx    = tx[CW-1:0];
            wy_nx    = ty[CW-1:0];
            state_nx = FETCH;
          end else begin
            bump_nx = 1'b1;
          end
        end
      end
      FETCH: state_nx = CHECK;
      CHECK: begin
        if (!wall_bit) begin
          px_nx = wall_x;
          py_nx = wall_y;
          if (moves != 16'hFFFF) moves_nx = moves + 16'd1;
        end else begin
          bump_nx = 1'b1;
        end
        if (px_nx == GOAL_X && py_nx == GOAL_Y) begin
          state_nx = WON;
          flush    = 1'b1;
        end else begin
          state_nx = RUN;
        end
      end
      WON: begin
        if (restart) begin
          state_nx = IDLE;
          px_nx    = START_X;
          py_nx    = START_Y;
          moves_nx = '0;
          flush    = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      player_x <= START_X;
      player_y <= START_Y;
      wall_x   <= '0;
      wall_y   <= '0;
      wall_rd  <= 1'b0;
      moves    <= '0;
      won      <= 1'b0;
      bump     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      state_q  <= state_nx;
      player_x <= px_nx;
      player_y <= py_nx;
      wall_x   <= wx_nx;
      wall_y   <= wy_nx;
      wall_rd  <= (state_nx == FETCH);
      moves    <= moves_nx;
      won      <= (state_nx == WON);
      bump     <= bump_nx;
      drop     <= drop_nx;
    end
  end

  assign state = state_q;

endmodule

// File: doc/note_move_sequencer.md
# note_move_sequencer

Game controller between the filtered-note detector and the maze renderer. Converts one-hot note events into queued move commands and executes one move per step strobe. Each move's wall check goes through a shared maze-ROM read port. The block tracks player position, move count and win state.

## Interface
Parameters:
- maze_w, 32, maze width in cells (≤ 32)
- maze_h, 18, maze height in cells (≤ 32)
- start_x / start_y, 1 / 1, player cell after reset or restart
- goal_x / goal_y, 31 / 15, finish cell
- fifo_depth, 4, command queue depth (power of 2, ≥ 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- note  in  12  one-hot note, C = bit 11 … B = bit 0
- note_vld  in  1  one-cycle pulse when a new filtered note settles
- step  in  1  one-cycle move strobe
- wall_rd  out  1  maze ROM read request
- wall_x / wall_y  out  5 / 5  ROM read address, valid while wall_rd = 1
- wall_bit  in  1  ROM data (1 = wall), valid the cycle after wall_rd
- player_x / player_y  out  5 / 5  current player cell
- state  out  3  FSM state
- moves  out  16  successful move count, saturating
- won  out  1  high in WON
- bump  out  1  one-cycle pulse on a blocked move
- drop  out  1  one-cycle pulse when a command is lost on a full queue

## Operation
- Note decode on note_vld:
  - C → LEFT, D → RIGHT, E → UP, F → DOWN.
  - A in WON → restart.
  - Any other note, including zero or multi-hot, is ignored.
- Push: a direction command is pushed in IDLE/RUN/FETCH/CHECK. Full queue with no same-cycle pop → command discarded, drop = 1. Full queue with a same-cycle pop → push accepted.
- FSM states: IDLE, RUN, FETCH, CHECK, WON.
  - IDLE → RUN on the first accepted push.
  - RUN: step with a non-empty queue pops the head and computes the target cell.
    - Target outside 0..maze_w-1 / 0..maze_h-1 (including 5-bit underflow at 0): no ROM read, bump = 1, stay in RUN.
    - Otherwise register wall_x/wall_y and go to FETCH.
  - FETCH: wall_rd = 1 for exactly this cycle → CHECK.
  - CHECK: sample wall_bit.
    - wall_bit = 0: update position, moves += 1 (holds at 0xFFFF).
    - wall_bit = 1: bump = 1.
    - Next state: WON if the position equals the goal, else RUN.
  - WON: queue flushed on entry; direction pushes ignored, no drop. A note → IDLE with position = start, moves = 0, queue empty.
- step outside RUN, or in RUN with an empty queue, has no effect and is not remembered.
- Reset mid-operation aborts any pending ROM check. No partial position update.

## Timing
- Reset values:
  - player = (start_x, start_y), state = IDLE, moves = 0, queue empty.
  - won, bump, drop, wall_rd = 0; wall_x/wall_y = 0.
- All outputs are registered.
- Step sampled in RUN at cycle t:
  - t+1: FETCH, wall_rd = 1.
  - t+2: CHECK, ROM data sampled.
  - t+3: new player_x/y, moves, bump visible; state = RUN or WON.
- Boundary-blocked step at t: bump visible at t+1.
- Max throughput: one move per 3 cycles.
- note_vld at t: queue occupancy visible at t+1; drop pulses at t+1.
- Restart A note at t: state = IDLE and player = start at t+1.

## Structure
- Package note_maze_pkg:
  - dir_t enum (LEFT, RIGHT, UP, DOWN)
  - state_t enum (IDLE, RUN, FETCH, CHECK, WON)
  - 12-bit one-hot note constants C…B
  - function note_to_dir
- Sub-module dir_fifo: synchronous FIFO of dir_t. Ports push, pop, flush, full, empty, dout. Pointers carry an extra wrap bit.
- All FSM, position and counter logic stays in note_move_sequencer.

## Test plan
- Reset, then note_vld with D, then step, ROM returns 0 → wall_rd at t+1 with (2,1); player (2,1), moves = 1 at t+3.
- Player at (1,1), E then step, ROM returns 1 → bump at t+3; player stays (1,1), moves = 0.
- Player forced to x = 0 (custom start_x = 0), C then step → bump at t+1, wall_rd never asserted.
- Five D notes with no steps, fifo_depth = 4 → drop pulse on the 5th push; then 4 steps produce exactly 4 ROM reads.
- Start at goal-1 (30,15), D then step, ROM returns 0 → state WON, won = 1. A following D note is ignored with no drop. An A note then returns to IDLE, player = start, moves = 0.
- rst asserted during FETCH → all outputs at reset values next cycle; no position update afterwards.
